// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C register-access sequencer:
//   - i2c_cmd_e   : command encodings understood by the I2C master
//   - ERR_*       : response error codes
//   - seq_state_e : per-phase handshake state (IDLE/ISSUE/GAP/WAIT)
//   - seq_phase_e : position inside the START..STOP command list
//   - next_phase / phase_cmd / phase_is_byte : phase-list helpers
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        CMD_START   = 3'd0,
        CMD_RESTART = 3'd1,
        CMD_STOP    = 3'd2,
        CMD_RD      = 3'd3,
        CMD_WR      = 3'd4
    } i2c_cmd_e;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // RD command operand: bit0 asks the master to NACK the (only) byte read.
    localparam logic [7:0] RD_NACK_LAST = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP,
        ST_WAIT
    } seq_state_e;

    typedef enum logic [3:0] {
        PH_START,
        PH_DEV_W,
        PH_REG_HI,
        PH_REG_LO,
        PH_WDATA,
        PH_RESTART,
        PH_DEV_R,
        PH_RD,
        PH_STOP
    } seq_phase_e;

    // Successor of a phase in the error-free command list.
    function automatic seq_phase_e next_phase(seq_phase_e ph, logic is_rd, logic two_bytes);
        seq_phase_e nxt;
        nxt = PH_STOP;
        case (ph)
            PH_START:   nxt = PH_DEV_W;
            PH_DEV_W:   nxt = two_bytes ? PH_REG_HI : PH_REG_LO;
            PH_REG_HI:  nxt = PH_REG_LO;
            PH_REG_LO:  nxt = is_rd ? PH_RESTART : PH_WDATA;
            PH_WDATA:   nxt = PH_STOP;
            PH_RESTART: nxt = PH_DEV_R;
            PH_DEV_R:   nxt = PH_RD;
            PH_RD:      nxt = PH_STOP;
            default:    nxt = PH_STOP;
        endcase
        return nxt;
    endfunction

    function automatic i2c_cmd_e phase_cmd(seq_phase_e ph);
        i2c_cmd_e cmd;
        cmd = CMD_WR;
        case (ph)
            PH_START:   cmd = CMD_START;
            PH_RESTART: cmd = CMD_RESTART;
            PH_STOP:    cmd = CMD_STOP;
            PH_RD:      cmd = CMD_RD;
            default:    cmd = CMD_WR;
        endcase
        return cmd;
    endfunction

    // Byte phases finish on m_done_tick; bus-condition phases finish on m_ready.
    function automatic logic phase_is_byte(seq_phase_e ph);
        i2c_cmd_e cmd;
        cmd = phase_cmd(ph);
        return (cmd == CMD_WR) || (cmd == CMD_RD);
    endfunction

endpackage

// File: rtl/i2c_reg_seq_if.sv
// ---------------------------------------------------------------------------
// i2c_reg_seq_if
// Bundles the register-request/response handshake and the I2C master command
// port of the sequencer.
//   req_*  : request from the register-bus bridge (req_valid/req_ready)
//   rsp_*  : one-cycle response back to the bridge
//   m_*    : command/status port of the I2C master
// Modports:
//   slave  : the sequencer's view (consumes requests, drives master commands)
//   master : the environment's view (bridge + I2C master side)
// ---------------------------------------------------------------------------
interface i2c_reg_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_rd;
    logic [6:0]  req_dev;
    logic [15:0] req_reg;
    logic [7:0]  req_wdata;

    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [1:0]  rsp_err;

    logic [2:0]  m_cmd;
    logic [7:0]  m_din;
    logic        m_wr_i2c;
    logic        m_ready;
    logic        m_done_tick;
    logic        m_ack;
    logic [7:0]  m_dout;

    modport slave (
        input  req_valid, req_rd, req_dev, req_reg, req_wdata,
        input  m_ready, m_done_tick, m_ack, m_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output m_cmd, m_din, m_wr_i2c
    );

    modport master (
        output req_valid, req_rd, req_dev, req_reg, req_wdata,
        output m_ready, m_done_tick, m_ack, m_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  m_cmd, m_din, m_wr_i2c
    );
endinterface

// File: rtl/i2c_seq_timer.sv
// ---------------------------------------------------------------------------
// i2c_seq_timer
// Per-command watchdog: counts enabled cycles since the last clear and flags
// when LIMIT cycles have elapsed. Saturates at LIMIT.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_clear      : restart the count at zero (has priority)
//   i_enable     : count this cycle
//   o_expired    : count has reached LIMIT
// ---------------------------------------------------------------------------
module i2c_seq_timer #(
    parameter int unsigned LIMIT = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == W'(LIMIT));
endmodule

// File: rtl/i2c_reg_seq.sv
// ---------------------------------------------------------------------------
// i2c_reg_seq
// Register-access sequencer in front of an I2C master. Takes one single-byte
// register read/write request, walks the START/WR/(RESTART/WR/RD)/STOP command
// list on the master's command port and returns one response pulse.
// Parameters:
//   REG_ADDR_BYTES : 1 or 2 register-address bytes (MSB first)
//   TIMEOUT_CYCLES : per-command watchdog limit in clk cycles
// Build option:
//   I2C_SEQ_TIMEOUT_EN : when defined, a watchdog aborts a stuck phase with
//                        err=10; when undefined, phases may wait forever.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset (aborts silently, no response)
//   bus     : i2c_reg_seq_if.slave (request, response, master command port)
// ---------------------------------------------------------------------------
module i2c_reg_seq
    import i2c_pkg::*;
#(
    parameter int          REG_ADDR_BYTES = 1,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic           clk,
    input  logic           reset_n,
    i2c_reg_seq_if.slave   bus
);
    localparam logic TWO_BYTES = (REG_ADDR_BYTES == 2);

    seq_state_e  r_state;
    seq_phase_e  r_phase;
    logic        r_rd;
    logic [6:0]  r_dev;
    logic [15:0] r_reg;
    logic [7:0]  r_wdata;
    logic [1:0]  r_err;
    logic [7:0]  r_rdata;

    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_rdata;
    logic [1:0]  r_rsp_err;
    i2c_cmd_e    r_m_cmd;
    logic [7:0]  r_m_din;
    logic        r_m_wr_i2c;

    logic [7:0]  w_din;
    logic        w_phase_done;
    logic        w_timeout;

    // Operand byte for the current phase.
    always_comb begin
        w_din = 8'h00;
        case (r_phase)
            PH_DEV_W:  w_din = {r_dev, 1'b0};
            PH_REG_HI: w_din = r_reg[15:8];
            PH_REG_LO: w_din = r_reg[7:0];
            PH_WDATA:  w_din = r_wdata;
            PH_DEV_R:  w_din = {r_dev, 1'b1};
            PH_RD:     w_din = RD_NACK_LAST;
            default:   w_din = 8'h00;
        endcase
    end

    assign w_phase_done = phase_is_byte(r_phase) ? bus.m_done_tick : bus.m_ready;

`ifdef I2C_SEQ_TIMEOUT_EN
    logic w_tmr_clear;
    logic w_tmr_enable;

    assign w_tmr_clear  = (r_state == ST_ISSUE);
    assign w_tmr_enable = (r_state == ST_GAP) || (r_state == ST_WAIT);

    i2c_seq_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_tmr_clear),
        .i_enable  (w_tmr_enable),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_phase     <= PH_START;
            r_rd        <= 1'b0;
            r_dev       <= '0;
            r_reg       <= '0;
            r_wdata     <= '0;
            r_err       <= ERR_OK;
            r_rdata     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= ERR_OK;
            r_m_cmd     <= CMD_STOP;
            r_m_din     <= '0;
            r_m_wr_i2c  <= 1'b0;
        end else begin
            r_m_wr_i2c  <= 1'b0;
            r_rsp_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // req_ready comes back one cycle after the response pulse,
                    // so acceptance is qualified by the registered ready.
                    r_req_ready <= 1'b1;
                    if (bus.req_valid && r_req_ready) begin
                        r_rd        <= bus.req_rd;
                        r_dev       <= bus.req_dev;
                        r_reg       <= bus.req_reg;
                        r_wdata     <= bus.req_wdata;
                        r_err       <= ERR_OK;
                        r_rdata     <= '0;
                        r_phase     <= PH_START;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (bus.m_ready) begin
                        r_m_cmd    <= phase_cmd(r_phase);
                        r_m_din    <= w_din;
                        r_m_wr_i2c <= 1'b1;
                        r_state    <= ST_GAP;
                    end
                end

                // The master needs a cycle to drop m_ready after the strobe.
                ST_GAP: begin
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    // Completion in the same cycle as expiry takes precedence.
                    if (w_phase_done) begin
                        if (r_phase == PH_STOP) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= r_err;
                            r_rsp_rdata <= (r_err == ERR_OK) ? r_rdata : 8'h00;
                            r_state     <= ST_IDLE;
                        end else if ((phase_cmd(r_phase) == CMD_WR) && bus.m_ack) begin
                            r_err   <= ERR_NACK;
                            r_phase <= PH_STOP;
                            r_state <= ST_ISSUE;
                        end else begin
                            if (r_phase == PH_RD) begin
                                r_rdata <= bus.m_dout;
                            end
                            r_phase <= next_phase(r_phase, r_rd, TWO_BYTES);
                            r_state <= ST_ISSUE;
                        end
                    end else if (w_timeout) begin
                        if (r_phase == PH_STOP) begin
                            // STOP itself hung: report right away, no retry.
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= ERR_TIMEOUT;
                            r_rsp_rdata <= 8'h00;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_err   <= ERR_TIMEOUT;
                            r_phase <= PH_STOP;
                            r_state <= ST_ISSUE;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.m_cmd     = r_m_cmd;
    assign bus.m_din     = r_m_din;
    assign bus.m_wr_i2c  = r_m_wr_i2c;
endmodule

// File: tb/tb_i2c_reg_seq.sv
`timescale 1ns/1ps
module tb_i2c_reg_seq;
    import i2c_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Two sequencers: 1-byte and 2-byte register address. 'sel' picks which
    // one receives req_valid and whose outputs the bench observes; the
    // master-model inputs go to both (the idle one ignores them).
    i2c_reg_seq_if bus1 ();
    i2c_reg_seq_if bus2 ();

    i2c_reg_seq #(.REG_ADDR_BYTES(1), .TIMEOUT_CYCLES(100)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave));
    i2c_reg_seq #(.REG_ADDR_BYTES(2), .TIMEOUT_CYCLES(100)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2.slave));

    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_rd = 1'b0;
    logic [6:0]  req_dev = '0;
    logic [15:0] req_reg = '0;
    logic [7:0]  req_wdata = '0;
    logic        m_ready = 1'b1;
    logic        m_done_tick = 1'b0;
    logic        m_ack = 1'b0;
    logic [7:0]  m_dout = '0;

    assign bus1.req_valid = req_valid & ~sel;
    assign bus2.req_valid = req_valid & sel;
    assign bus1.req_rd = req_rd;       assign bus2.req_rd = req_rd;
    assign bus1.req_dev = req_dev;     assign bus2.req_dev = req_dev;
    assign bus1.req_reg = req_reg;     assign bus2.req_reg = req_reg;
    assign bus1.req_wdata = req_wdata; assign bus2.req_wdata = req_wdata;
    assign bus1.m_ready = m_ready;     assign bus2.m_ready = m_ready;
    assign bus1.m_done_tick = m_done_tick; assign bus2.m_done_tick = m_done_tick;
    assign bus1.m_ack = m_ack;         assign bus2.m_ack = m_ack;
    assign bus1.m_dout = m_dout;       assign bus2.m_dout = m_dout;

    wire       w_req_ready = sel ? bus2.req_ready : bus1.req_ready;
    wire       w_rsp_valid = sel ? bus2.rsp_valid : bus1.rsp_valid;
    wire [7:0] w_rsp_rdata = sel ? bus2.rsp_rdata : bus1.rsp_rdata;
    wire [1:0] w_rsp_err   = sel ? bus2.rsp_err   : bus1.rsp_err;
    wire [2:0] w_m_cmd     = sel ? bus2.m_cmd     : bus1.m_cmd;
    wire [7:0] w_m_din     = sel ? bus2.m_din     : bus1.m_din;
    wire       w_wr_i2c    = sel ? bus2.m_wr_i2c  : bus1.m_wr_i2c;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rsp_cnt = 0;
    always @(negedge clk) if (bus1.rsp_valid || bus2.rsp_valid) rsp_cnt++;

    // ---------------- I2C master model (driven on the falling edge) --------
    int          nack_idx = -1;   // index of WR byte (from START) answered with NACK
    bit          stall = 1'b0;    // byte phases never produce m_done_tick
    bit          hold_ready = 1'b0;
    logic [7:0]  dout_val = 8'h00;
    logic [11:0] log_q[$];        // {0,cmd,din} per strobe
    int          log_cyc[$];
    bit          busy = 1'b0;
    int          cnt = 0;
    int          wr_idx = 0;
    int          cur_idx = 0;
    logic [2:0]  cur_cmd = 3'd0;

    always @(negedge clk) begin
        m_done_tick = 1'b0;
        m_ack = 1'b0;
        if (!reset_n) begin
            busy = 1'b0; cnt = 0; wr_idx = 0;
            m_ready = !hold_ready;
        end else if (w_wr_i2c) begin
            log_q.push_back({1'b0, w_m_cmd, w_m_din});
            log_cyc.push_back(cyc);
            if (w_m_cmd == CMD_START) wr_idx = 0;
            cur_cmd = w_m_cmd;
            cur_idx = wr_idx;
            if (w_m_cmd == CMD_WR) wr_idx++;
            busy = 1'b1; cnt = 2; m_ready = 1'b0;
        end else if (busy) begin
            if (cnt > 0) cnt--;
            else begin
                busy = 1'b0;
                m_ready = 1'b1;
                if ((cur_cmd == CMD_WR || cur_cmd == CMD_RD) && !stall) begin
                    m_done_tick = 1'b1;
                    m_ack = (cur_cmd == CMD_WR) && (cur_idx == nack_idx);
                    m_dout = dout_val;
                end
            end
        end else begin
            m_ready = !hold_ready;
        end
    end

    // ---------------- checking helpers ----------------
    int total = 0;
    int bad = 0;
    int acc_cyc = 0;
    logic [11:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_txn(input logic d, input logic rd, input logic [6:0] dev,
                             input logic [15:0] rg, input logic [7:0] wd);
        sel = d; req_rd = rd; req_dev = dev; req_reg = rg; req_wdata = wd;
        log_q.delete(); log_cyc.delete();
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic finish_txn(input string tag, input logic [1:0] exp_err, input logic [7:0] exp_rdata);
        logic got;
        for (int i = 0; i < 400 && !w_rsp_valid; i++) @(negedge clk);
        got = w_rsp_valid;
        check({tag, "_rsp_seen"}, 32'(got), 32'd1);
        check({tag, "_err"}, 32'(w_rsp_err), 32'(exp_err));
        check({tag, "_rdata"}, 32'(w_rsp_rdata), 32'(exp_rdata));
        check({tag, "_ready_in_rsp"}, 32'(w_req_ready), 32'd0);
        @(negedge clk);
        check({tag, "_rsp_1cyc"}, 32'(w_rsp_valid), 32'd0);
        check({tag, "_ready_after"}, 32'(w_req_ready), 32'd1);
        $display("txn %s: err=%0d rdata=0x%02h cmds=%0d", tag, w_rsp_err, w_rsp_rdata, log_q.size());
    endtask

    task automatic check_seq(input string tag);
        int n;
        check({tag, "_ncmd"}, 32'(log_q.size()), 32'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_cmd%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int snap;
        repeat (3) @(negedge clk);
        check("rst_ready1", 32'(bus1.req_ready), 32'd1);
        check("rst_rspv1", 32'(bus1.rsp_valid), 32'd0);
        check("rst_cmd1", 32'(bus1.m_cmd), 32'(CMD_STOP));
        check("rst_wr1", 32'(bus1.m_wr_i2c), 32'd0);
        check("rst_ready2", 32'(bus2.req_ready), 32'd1);
        check("rst_cmd2", 32'(bus2.m_cmd), 32'(CMD_STOP));
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: write, 1-byte register address
        start_txn(1'b0, 1'b0, 7'h50, 16'h0012, 8'hA5);
        check("t1_ready_low", 32'(w_req_ready), 32'd0);
        finish_txn("t1", ERR_OK, 8'h00);
        exp_q = '{12'h000, 12'h4A0, 12'h412, 12'h4A5, 12'h200};
        check_seq("t1");
        check("t1_latency", 32'(log_cyc[0] - acc_cyc), 32'd1);

        // 2: read
        dout_val = 8'h5C;
        start_txn(1'b0, 1'b1, 7'h50, 16'h0034, 8'h00);
        finish_txn("t2", ERR_OK, 8'h5C);
        exp_q = '{12'h000, 12'h4A0, 12'h434, 12'h100, 12'h4A1, 12'h301, 12'h200};
        check_seq("t2");

        // reset in the middle of a read: silent abort
        start_txn(1'b0, 1'b1, 7'h50, 16'h0034, 8'h00);
        repeat (12) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rstm_ready", 32'(bus1.req_ready), 32'd1);
        check("rstm_rspv", 32'(bus1.rsp_valid), 32'd0);
        check("rstm_rdata", 32'(bus1.rsp_rdata), 32'd0);
        check("rstm_err", 32'(bus1.rsp_err), 32'd0);
        check("rstm_cmd", 32'(bus1.m_cmd), 32'(CMD_STOP));
        check("rstm_din", 32'(bus1.m_din), 32'd0);
        check("rstm_wr", 32'(bus1.m_wr_i2c), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        snap = rsp_cnt;
        log_q.delete();
        repeat (30) @(negedge clk);
        check("rstm_no_rsp", 32'(rsp_cnt), 32'(snap));
        check("rstm_no_cmd", 32'(log_q.size()), 32'd0);
        $display("txn rst_mid_read: rsp_cnt=%0d cmds_after=%0d", rsp_cnt, log_q.size());

        // 3: NACK on device byte of a read
        nack_idx = 0;
        start_txn(1'b0, 1'b1, 7'h50, 16'h0034, 8'h00);
        finish_txn("t3", ERR_NACK, 8'h00);
        exp_q = '{12'h000, 12'h4A0, 12'h200};
        check_seq("t3");
        nack_idx = -1;

        // 4: two-byte register address write
        start_txn(1'b1, 1'b0, 7'h50, 16'hBEEF, 8'h3C);
        finish_txn("t4", ERR_OK, 8'h00);
        exp_q = '{12'h000, 12'h4A0, 12'h4BE, 12'h4EF, 12'h43C, 12'h200};
        check_seq("t4");

        // 4b: two-byte read, NACK on the repeated device byte
        nack_idx = 3;
        dout_val = 8'h99;
        start_txn(1'b1, 1'b1, 7'h2A, 16'h0102, 8'h00);
        finish_txn("t4b", ERR_NACK, 8'h00);
        exp_q = '{12'h000, 12'h454, 12'h401, 12'h402, 12'h100, 12'h455, 12'h200};
        check_seq("t4b");
        nack_idx = -1;

        // 5: master not ready, second request while busy
        hold_ready = 1'b1;
        repeat (2) @(negedge clk);
        snap = rsp_cnt;
        start_txn(1'b0, 1'b0, 7'h7F, 16'h00FF, 8'h00);
        repeat (5) @(negedge clk);
        req_rd = 1'b1; req_dev = 7'h11; req_reg = 16'h0022; req_wdata = 8'h33;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (14) @(negedge clk);
        check("t5_no_strobe", 32'(log_q.size()), 32'd0);
        hold_ready = 1'b0;
        finish_txn("t5", ERR_OK, 8'h00);
        repeat (20) @(negedge clk);
        exp_q = '{12'h000, 12'h4FE, 12'h4FF, 12'h400, 12'h200};
        check_seq("t5");
        check("t5_one_rsp", 32'(rsp_cnt - snap), 32'd1);

`ifdef I2C_SEQ_TIMEOUT_EN
        // 6: first WR never completes
        begin
            logic in_window;
            stall = 1'b1;
            start_txn(1'b0, 1'b0, 7'h50, 16'h0012, 8'hA5);
            finish_txn("t6", ERR_TIMEOUT, 8'h00);
            stall = 1'b0;
            exp_q = '{12'h000, 12'h4A0, 12'h200};
            check_seq("t6");
            in_window = (log_cyc.size() == 3) &&
                        (log_cyc[2] - log_cyc[1] >= 100) && (log_cyc[2] - log_cyc[1] <= 103);
            check("t6_stop_window", 32'(in_window), 32'd1);
        end
`endif

        // recovery write after everything above
        start_txn(1'b0, 1'b0, 7'h01, 16'h0080, 8'h7E);
        finish_txn("t7", ERR_OK, 8'h00);
        exp_q = '{12'h000, 12'h402, 12'h480, 12'h47E, 12'h200};
        check_seq("t7");
        check("t7_latency", 32'(log_cyc[0] - acc_cyc), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
